ysyx_23060077_riscv_ibuf: RTL and testbench

YSYX_23060077_RISCV_IBUF -- requirements
Module: ysyx_23060077_riscv_ibuf

---
 rtl/ysyx_23060077_riscv_ibuf_pkg.sv | 14 +
 rtl/ysyx_23060077_riscv_ibuf.sv | 66 ++++++
 tb/tb_ysyx_23060077_riscv_ibuf.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_riscv_ibuf_pkg.sv
// Shared widths, encodings and entry layout for the IFU->IDU instruction buffer.
package ysyx_23060077_riscv_ibuf_pkg;
  localparam int INST_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [INST_WIDTH-1:0] RST_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [INST_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/ysyx_23060077_riscv_ibuf.sv
// Small FIFO decoupling IFU fetch from IDU decode. Handshakes are driven
// only from registered occupancy, so no ready/valid path crosses the buffer.
module ysyx_23060077_riscv_ibuf
  import ysyx_23060077_riscv_ibuf_pkg::*;
#(
  parameter int                    DEPTH  = 2,
  parameter logic [INST_WIDTH-1:0] RST_PC = RST_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu_valid_i,
  input  logic [INST_WIDTH-1:0]      ifu_pc_i,
  input  logic [INST_WIDTH-1:0]      ifu_inst_i,
  output logic                       ifu_ready_o,
  input  logic                       flush_i,
  output logic                       idu_valid_o,
  input  logic                       idu_ready_i,
  output logic [INST_WIDTH-1:0]      idu_pc_o,
  output logic [INST_WIDTH-1:0]      idu_inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ibuf_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  assign ifu_ready_o = (count < CNT_W'(DEPTH));
  assign idu_valid_o = (count != '0);

  // A redirect kills both sides of the handshake in the same cycle.
  assign push = ifu_valid_i & ifu_ready_o & ~flush_i;
  assign pop  = idu_valid_o & idu_ready_i & ~flush_i;

  // Head entry straight from storage; stale contents show when empty.
  assign idu_pc_o   = mem[rd_ptr].pc;
  assign idu_inst_o = mem[rd_ptr].inst;
  assign count_o    = count;

  // Entry storage: reset to NOPs at RST_PC, written only on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: RST_PC, inst: NOP_INST};
    end else if (push) begin
      mem[wr_ptr] <= '{pc: ifu_pc_i, inst: ifu_inst_i};
    end
  end

  // Pointers and occupancy; flush empties by snapping rd_ptr onto wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_riscv_ibuf.sv
// Directed bench for the instruction buffer: queue model checked every cycle
// plus literal expectations at the key points.
module tb_ysyx_23060077_riscv_ibuf;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_valid_i = 1'b0;
  logic [31:0] ifu_pc_i = '0;
  logic [31:0] ifu_inst_i = '0;
  logic        ifu_ready_o;
  logic        flush_i = 1'b0;
  logic        idu_valid_o;
  logic        idu_ready_i = 1'b0;
  logic [31:0] idu_pc_o;
  logic [31:0] idu_inst_o;
  logic [1:0]  count_o;

  int total = 0;
  int bad   = 0;

  ysyx_23060077_riscv_ibuf #(.DEPTH(DEPTH), .RST_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_valid_i(ifu_valid_i), .ifu_pc_i(ifu_pc_i), .ifu_inst_i(ifu_inst_i),
    .ifu_ready_o(ifu_ready_o), .flush_i(flush_i),
    .idu_valid_o(idu_valid_o), .idu_ready_i(idu_ready_i),
    .idu_pc_o(idu_pc_o), .idu_inst_o(idu_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Model: contents in arrival order, nothing more.
  logic [63:0] q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      automatic bit mpush = ifu_valid_i && (q.size() < DEPTH) && !flush_i;
      automatic bit mpop  = (q.size() != 0) && idu_ready_i && !flush_i;
      if (flush_i) q.delete();
      else begin
        if (mpop)  void'(q.pop_front());
        if (mpush) q.push_back({ifu_pc_i, ifu_inst_i});
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ready", 32'(ifu_ready_o), 32'(q.size() < DEPTH));
      chk("m_valid", 32'(idu_valid_o), 32'(q.size() != 0));
      chk("m_count", 32'(count_o), 32'(q.size()));
      if (q.size() != 0) begin
        chk("m_pc", idu_pc_o, q[0][63:32]);
        chk("m_inst", idu_inst_o, q[0][31:0]);
      end
    end
  end

  task automatic cyc(bit v, logic [31:0] pc, logic [31:0] inst, bit rdy, bit fl);
    ifu_valid_i = v; ifu_pc_i = pc; ifu_inst_i = inst;
    idu_ready_i = rdy; flush_i = fl;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, 32'(ifu_ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(idu_valid_o), 32'd0);
    chk({tag, "_pc"}, idu_pc_o, 32'h8000_0000);
    chk({tag, "_inst"}, idu_inst_o, 32'h0000_0013);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and release
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("in_rst");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk_reset_vals("post_rst");

    // Single push, latency one
    cyc(1, 32'h8000_0000, 32'h0010_0093, 0, 0);
    chk("p1_valid", 32'(idu_valid_o), 32'd1);
    chk("p1_pc", idu_pc_o, 32'h8000_0000);
    chk("p1_inst", idu_inst_o, 32'h0010_0093);
    chk("p1_count", 32'(count_o), 32'd1);

    // Fill, blocked third push, one pop
    cyc(1, 32'h8000_0004, 32'h0020_0113, 0, 0);
    chk("full_count", 32'(count_o), 32'd2);
    chk("full_ready", 32'(ifu_ready_o), 32'd0);
    cyc(1, 32'h8000_0008, 32'h0030_0193, 0, 0);
    chk("blk_count", 32'(count_o), 32'd2);
    chk("blk_pc", idu_pc_o, 32'h8000_0000);
    cyc(0, 0, 0, 1, 0);
    chk("pop_ready", 32'(ifu_ready_o), 32'd1);
    chk("pop_pc", idu_pc_o, 32'h8000_0004);
    chk("pop_count", 32'(count_o), 32'd1);

    // Full + flush with push and pop requested
    cyc(1, 32'h8000_000c, 32'h0040_0213, 0, 0);
    chk("refill_count", 32'(count_o), 32'd2);
    cyc(1, 32'h8000_0010, 32'h0050_0293, 1, 1);
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_valid", 32'(idu_valid_o), 32'd0);
    chk("fl_ready", 32'(ifu_ready_o), 32'd1);
    cyc(1, 32'h8000_0100, 32'h0060_0313, 0, 0);
    chk("afl_valid", 32'(idu_valid_o), 32'd1);
    chk("afl_pc", idu_pc_o, 32'h8000_0100);
    chk("afl_inst", idu_inst_o, 32'h0060_0313);
    cyc(0, 0, 0, 1, 0);
    chk("drain_count", 32'(count_o), 32'd0);

    // Streaming: push into empty with ready high must not pop
    cyc(1, 32'h8000_0000, 32'h1000_0013, 1, 0);
    chk("s0_count", 32'(count_o), 32'd1);
    chk("s0_pc", idu_pc_o, 32'h8000_0000);
    for (int n = 1; n <= 16; n++) begin
      cyc(1, 32'h8000_0000 + 32'(4 * n), 32'h1000_0013 + 32'(n), 1, 0);
      chk("s_count", 32'(count_o), 32'd1);
      chk("s_pc", idu_pc_o, 32'h8000_0000 + 32'(4 * n));
      chk("s_inst", idu_inst_o, 32'h1000_0013 + 32'(n));
    end

    // Async reset between edges while still streaming
    ifu_valid_i = 1'b1; ifu_pc_i = 32'h8000_0044; idu_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk_reset_vals("rel2");
    cyc(1, 32'h8000_0200, 32'h0070_0393, 0, 0);
    chk("rel2_pc", idu_pc_o, 32'h8000_0200);
    chk("rel2_count", 32'(count_o), 32'd1);
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
